lap_record_ctrl: RTL and testbench
==================================

LAP_RECORD_CTRL -- requirements
Module: lap_record_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: lap memory entries; the index range 0..DEPTH feeds the 5-bit BCD index display.
REQ-002 SHALL have parameter DW, default 24: width of one lap time word (packed BCD min/sec/centisec).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mode_sw  input  1  level; 1 = stopwatch mode active.
REQ-006 SHALL have port rec_pulse  input  1  one-cycle pulse; store lap, or leave browse.
REQ-007 SHALL have ports next_pulse, prev_pulse  input  1 each  one-cycle browse pulses.
REQ-008 SHALL have port clr_pulse  input  1  one-cycle pulse; discard all laps.
REQ-009 SHALL have port time_in  input  DW  current running time, sampled on rec_pulse.
REQ-010 SHALL have port disp_en  output  1  index display enable.
REQ-011 SHALL have port idx_out  output  5  binary index 0..DEPTH for the BCD converter.
REQ-012 SHALL have port lap_out  output  DW  lap word currently being browsed.
REQ-013 SHALL have ports cnt  output  5  and full  output  1  stored-lap count and count==DEPTH flag.

Function
REQ-014 SHALL implement FSM states OFF, REC, BROWSE; all outputs SHALL be registered.
REQ-015 OFF: disp_en=0, idx_out=0, lap_out=0; mode_sw=1 -> REC on the next edge; cnt and memory SHALL be retained.
REQ-016 mode_sw=0 in any state -> OFF on the next edge, overriding all pulses.
REQ-017 REC: disp_en=1, idx_out=cnt; rec_pulse with cnt<DEPTH -> mem[cnt]<=time_in and cnt+1, visible 1 cycle later.
REQ-018 REC with cnt==DEPTH: rec_pulse SHALL be ignored (no write, cnt holds); full=1.
REQ-019 REC: next_pulse or prev_pulse with cnt>0 -> BROWSE; ptr=0 for next, ptr=cnt-1 for prev; with cnt==0 both SHALL be ignored.
REQ-020 BROWSE: idx_out=ptr+1 (range 1..cnt); lap_out=mem[ptr] one cycle after ptr settles.
REQ-021 BROWSE: next wraps cnt-1 -> 0; prev wraps 0 -> cnt-1; rec_pulse -> REC with no write; lap_out SHALL hold its last value.
REQ-022 Pulse priority in one cycle SHALL be clr > rec > next/prev; next and prev together SHALL produce no move.
REQ-023 clr_pulse in REC or BROWSE -> cnt=0, ptr=0, lap_out=0, state REC; memory contents SHALL NOT be erased.
REQ-024 full SHALL equal (cnt==DEPTH) combinationally from the registered cnt.

Reset
REQ-025 rst_n low SHALL asynchronously force state OFF, cnt=0, ptr=0, disp_en=0, idx_out=0, lap_out=0, full=0.
REQ-026 Reset mid-write or mid-browse SHALL abort the operation; memory array SHALL NOT be reset and is undefined until written.
REQ-027 Release SHALL be synchronous to clk; the first transition SHALL occur on the first edge after rst_n rises.

Structure
REQ-028 State encoding, DEPTH and DW defaults SHALL live in a shared package used by the stopwatch top level.
REQ-029 SHALL contain one sub-module lap_mem: DEPTH x DW, one synchronous write port and one registered read port.
REQ-030 The FSM, cnt/ptr counters and the wrap logic SHALL reside in lap_record_ctrl.

Verification
REQ-031 Reset, mode_sw=1, three rec_pulses with time_in=0x000105, 0x000210, 0x000333 -> cnt=3, idx_out=3, disp_en=1.
REQ-032 Sixteen rec_pulses, then a 17th -> cnt=16, full=1, idx_out=16, mem[15] unchanged by the 17th pulse.
REQ-033 cnt=3, next x4 -> idx_out 1,2,3,1; prev from ptr=0 -> idx_out=3, lap_out=0x000333 one cycle later.
REQ-034 BROWSE, clr_pulse and next_pulse in the same cycle -> state REC, cnt=0, idx_out=0, lap_out=0.
REQ-035 mode_sw=0 during BROWSE -> disp_en=0 next cycle; mode_sw=1 -> REC with cnt preserved.
REQ-036 rst_n asserted mid-cycle during rec_pulse -> outputs zero immediately, cnt=0 after release.

Source files
------------

// File: rtl/lap_record_ctrl_pkg.sv
// Shared types and defaults for the stopwatch lap recorder.
package lap_record_ctrl_pkg;

   localparam int LAP_DEPTH = 16;
   localparam int LAP_DW    = 24;
   localparam int IDX_W     = 5;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_REC    = 2'd1,
      ST_BROWSE = 2'd2
   } lap_state_t;

endpackage

// File: rtl/lap_record_ctrl_if.sv
// Control/display bundle between the stopwatch top level and the lap recorder.
// Pulses are single-cycle strobes sampled on the rising clock edge; outputs are registered.
interface lap_record_ctrl_if
   import lap_record_ctrl_pkg::*;
#(
   parameter int DW = LAP_DW
);
   logic             mode_sw;
   logic             rec_pulse;
   logic             next_pulse;
   logic             prev_pulse;
   logic             clr_pulse;
   logic [DW-1:0]    time_in;
   logic             disp_en;
   logic [IDX_W-1:0] idx_out;
   logic [DW-1:0]    lap_out;
   logic [IDX_W-1:0] cnt;
   logic             full;
   lap_state_t       dbg_state;

   modport master (
      output mode_sw, rec_pulse, next_pulse, prev_pulse, clr_pulse, time_in,
      input  disp_en, idx_out, lap_out, cnt, full, dbg_state
   );

   modport slave (
      input  mode_sw, rec_pulse, next_pulse, prev_pulse, clr_pulse, time_in,
      output disp_en, idx_out, lap_out, cnt, full, dbg_state
   );
endinterface

// File: rtl/lap_record_ctrl_lap_mem.sv
// Lap storage: one synchronous write port, one registered read port, no reset on the array.
module lap_mem #(
   parameter int DEPTH = 16,
   parameter int DW    = 24,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data
);
   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/lap_record_ctrl.sv
// Lap record/browse controller: OFF/REC/BROWSE FSM, lap count and browse pointer.
module lap_record_ctrl
   import lap_record_ctrl_pkg::*;
#(
   parameter int DEPTH = LAP_DEPTH,
   parameter int DW    = LAP_DW
) (
   input logic              clk,
   input logic              rst_n,
   lap_record_ctrl_if.slave bus
);
   localparam int               AW      = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);

   lap_state_t       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
   logic [AW-1:0]    r_ptr, w_ptr_nxt;
   logic             r_disp_en, w_disp_en_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic [DW-1:0]    r_lap, w_lap_nxt;
   logic             w_wr_en;
   logic [DW-1:0]    w_rd_data;
   logic             w_mv_next, w_mv_prev, w_has_laps, w_ptr_last;

   // Simultaneous next and prev cancel each other.
   assign w_mv_next  = bus.next_pulse & ~bus.prev_pulse;
   assign w_mv_prev  = bus.prev_pulse & ~bus.next_pulse;
   assign w_has_laps = (r_cnt != '0);
   assign w_ptr_last = (IDX_W'(r_ptr) == r_cnt - IDX_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_OFF;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_OFF:    if (bus.mode_sw) w_state_nxt = ST_REC;
         ST_REC:    if (!bus.clr_pulse && !bus.rec_pulse && (w_mv_next || w_mv_prev) && w_has_laps)
                       w_state_nxt = ST_BROWSE;
         ST_BROWSE: if (bus.clr_pulse || bus.rec_pulse) w_state_nxt = ST_REC;
         default:   w_state_nxt = ST_OFF;
      endcase
      if (!bus.mode_sw) w_state_nxt = ST_OFF;
   end

   // Next values for counters and the registered outputs; priority clr > rec > move.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_ptr_nxt = r_ptr;
      w_lap_nxt = r_lap;
      w_wr_en   = 1'b0;
      if (!bus.mode_sw) begin
         w_lap_nxt = '0;
      end else begin
         case (r_state)
            ST_REC: begin
               if (bus.clr_pulse) begin
                  w_cnt_nxt = '0;
                  w_ptr_nxt = '0;
                  w_lap_nxt = '0;
               end else if (bus.rec_pulse) begin
                  if (r_cnt < DEPTH_C) begin
                     w_wr_en   = 1'b1;
                     w_cnt_nxt = r_cnt + IDX_W'(1);
                  end
               end else if (w_mv_next && w_has_laps) begin
                  w_ptr_nxt = '0;
               end else if (w_mv_prev && w_has_laps) begin
                  w_ptr_nxt = AW'(r_cnt - IDX_W'(1));
               end
            end
            ST_BROWSE: begin
               if (bus.clr_pulse) begin
                  w_cnt_nxt = '0;
                  w_ptr_nxt = '0;
                  w_lap_nxt = '0;
               end else if (!bus.rec_pulse) begin
                  w_lap_nxt = w_rd_data;
                  if (w_mv_next)
                     w_ptr_nxt = w_ptr_last ? '0 : r_ptr + AW'(1);
                  else if (w_mv_prev)
                     w_ptr_nxt = (r_ptr == '0) ? AW'(r_cnt - IDX_W'(1)) : r_ptr - AW'(1);
               end
            end
            default: ;
         endcase
      end
      w_disp_en_nxt = (w_state_nxt != ST_OFF);
      case (w_state_nxt)
         ST_REC:    w_idx_nxt = w_cnt_nxt;
         ST_BROWSE: w_idx_nxt = IDX_W'(w_ptr_nxt) + IDX_W'(1);
         default:   w_idx_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_ptr     <= '0;
         r_disp_en <= 1'b0;
         r_idx     <= '0;
         r_lap     <= '0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_ptr     <= w_ptr_nxt;
         r_disp_en <= w_disp_en_nxt;
         r_idx     <= w_idx_nxt;
         r_lap     <= w_lap_nxt;
      end
   end

   // Reading at the next pointer makes mem[ptr] available the cycle after ptr settles.
   lap_mem #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_lap_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (AW'(r_cnt)),
      .i_wr_data (bus.time_in),
      .i_rd_addr (w_ptr_nxt),
      .o_rd_data (w_rd_data)
   );

   assign bus.disp_en   = r_disp_en;
   assign bus.idx_out   = r_idx;
   assign bus.lap_out   = r_lap;
   assign bus.cnt       = r_cnt;
   assign bus.full      = (r_cnt == DEPTH_C);
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_lap_record_ctrl.sv
// Directed bench for lap_record_ctrl: record, browse/wrap, clear, mode switch, async reset.
module tb_lap_record_ctrl;
   import lap_record_ctrl_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   int   n_fail;

   lap_record_ctrl_if bus ();

   lap_record_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One-cycle pulse combination, then back to idle.
   task automatic drive(input logic rec, input logic nxt, input logic prv, input logic clr,
                        input logic [23:0] t);
      bus.rec_pulse  = rec;
      bus.next_pulse = nxt;
      bus.prev_pulse = prv;
      bus.clr_pulse  = clr;
      bus.time_in    = t;
      tick();
      bus.rec_pulse  = 1'b0;
      bus.next_pulse = 1'b0;
      bus.prev_pulse = 1'b0;
      bus.clr_pulse  = 1'b0;
   endtask

   initial begin
      logic [23:0] exp_idx1 [4];
      logic [23:0] exp_lap1 [4];
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;
      rst_n          = 1'b0;
      bus.mode_sw    = 1'b0;
      bus.rec_pulse  = 1'b0;
      bus.next_pulse = 1'b0;
      bus.prev_pulse = 1'b0;
      bus.clr_pulse  = 1'b0;
      bus.time_in    = '0;
      exp_idx1 = '{24'd1, 24'd2, 24'd3, 24'd1};
      exp_lap1 = '{24'h000105, 24'h000210, 24'h000333, 24'h000105};

      tick();
      tick();
      check("rst_disp_en", 32'(bus.disp_en), 32'd0);
      check("rst_idx",     32'(bus.idx_out), 32'd0);
      check("rst_lap",     32'(bus.lap_out), 32'd0);
      check("rst_cnt",     32'(bus.cnt),     32'd0);
      check("rst_full",    32'(bus.full),    32'd0);
      check("rst_state",   32'(bus.dbg_state), 32'(ST_OFF));

      rst_n       = 1'b1;
      bus.mode_sw = 1'b1;
      tick();
      check("on_state",   32'(bus.dbg_state), 32'(ST_REC));
      check("on_disp_en", 32'(bus.disp_en),   32'd1);

      drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      check("next_empty_state", 32'(bus.dbg_state), 32'(ST_REC));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
      check("prev_empty_idx", 32'(bus.idx_out), 32'd0);

      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h000105);
      check("rec1_cnt", 32'(bus.cnt), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h000210);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h000333);
      check("rec3_cnt",     32'(bus.cnt),     32'd3);
      check("rec3_idx",     32'(bus.idx_out), 32'd3);
      check("rec3_disp_en", 32'(bus.disp_en), 32'd1);

      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
         check($sformatf("next%0d_idx", i), 32'(bus.idx_out), 32'(exp_idx1[i]));
         tick();
         check($sformatf("next%0d_lap", i), 32'(bus.lap_out), 32'(exp_lap1[i]));
      end
      check("browse_state", 32'(bus.dbg_state), 32'(ST_BROWSE));

      drive(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
      check("prev_wrap_idx", 32'(bus.idx_out), 32'd3);
      tick();
      check("prev_wrap_lap", 32'(bus.lap_out), 32'h000333);

      drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
      check("both_idx", 32'(bus.idx_out), 32'd3);
      tick();
      check("both_lap", 32'(bus.lap_out), 32'h000333);

      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h000999);
      check("rec_leave_state", 32'(bus.dbg_state), 32'(ST_REC));
      check("rec_leave_cnt",   32'(bus.cnt),       32'd3);
      check("rec_leave_idx",   32'(bus.idx_out),   32'd3);
      check("rec_leave_lap",   32'(bus.lap_out),   32'h000333);

      drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      tick();
      check("rebrowse_lap", 32'(bus.lap_out), 32'h000105);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 24'h0);
      check("clr_state", 32'(bus.dbg_state), 32'(ST_REC));
      check("clr_cnt",   32'(bus.cnt),       32'd0);
      check("clr_idx",   32'(bus.idx_out),   32'd0);
      check("clr_lap",   32'(bus.lap_out),   32'd0);

      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h100000 | 24'(i));
         if (i == 14) check("cnt15_full", 32'(bus.full), 32'd0);
      end
      check("fill_cnt",  32'(bus.cnt),     32'd16);
      check("fill_full", 32'(bus.full),    32'd1);
      check("fill_idx",  32'(bus.idx_out), 32'd16);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF);
      check("over_cnt",  32'(bus.cnt),     32'd16);
      check("over_full", 32'(bus.full),    32'd1);
      check("over_idx",  32'(bus.idx_out), 32'd16);

      drive(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
      check("last_idx", 32'(bus.idx_out), 32'd16);
      tick();
      check("mem15_lap", 32'(bus.lap_out), 32'h10000F);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      check("wrap_idx", 32'(bus.idx_out), 32'd1);
      tick();
      check("wrap_lap", 32'(bus.lap_out), 32'h100000);

      bus.mode_sw = 1'b0;
      tick();
      check("off_disp_en", 32'(bus.disp_en),   32'd0);
      check("off_idx",     32'(bus.idx_out),   32'd0);
      check("off_lap",     32'(bus.lap_out),   32'd0);
      check("off_state",   32'(bus.dbg_state), 32'(ST_OFF));
      check("off_cnt",     32'(bus.cnt),       32'd16);
      bus.mode_sw = 1'b1;
      tick();
      check("back_state", 32'(bus.dbg_state), 32'(ST_REC));
      check("back_idx",   32'(bus.idx_out),   32'd16);

      drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h000111);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h000222);
      check("pre_rst_cnt", 32'(bus.cnt), 32'd2);
      bus.rec_pulse = 1'b1;
      bus.time_in   = 24'h000777;
      #3;
      rst_n = 1'b0;
      #1;
      check("async_disp_en", 32'(bus.disp_en), 32'd0);
      check("async_idx",     32'(bus.idx_out), 32'd0);
      check("async_cnt",     32'(bus.cnt),     32'd0);
      check("async_lap",     32'(bus.lap_out), 32'd0);
      bus.rec_pulse = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("release_state", 32'(bus.dbg_state), 32'(ST_REC));
      check("release_cnt",   32'(bus.cnt),       32'd0);
      check("release_idx",   32'(bus.idx_out),   32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
